jzjpcc_fetch_buffered: RTL and testbench

Next-generation fetch stage. It decouples instruction fetch from decode with a parametrised prefetch FIFO, so fetch continues while decode is stalled. It drives the synchronous instruction SRAM address port with a credit-limited request stream and feeds the decode-stage registers (instruction_decode, currentPC_decode). Control transfers from decode squash buffered and in-flight instructions and redirect fetch in the same cycle.

---
 rtl/jzjpcc_fetch_pkg.sv | 23 ++
 rtl/jzjpcc_fetch_buffered_if.sv | 45 ++++
 rtl/jzjpcc_fetch_fifo.sv | 58 +++++
 rtl/jzjpcc_fetch_buffered.sv | 115 +++++++++++
 tb/tb_jzjpcc_fetch_buffered.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/jzjpcc_fetch_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : jzjpcc_fetch_pkg
//  Purpose  : Shared constants and helpers for the buffered fetch stage.
//             - NOP_INSTR_30 : addi x0,x0,0 with the two low bits dropped,
//                              matching the [31:2] instruction buses.
//             - pc_width()   : width of a word-addressed PC given its MSB index.
//             Prefetch entries are carried as the packed concatenation
//             {instr[31:2], pc[PC_MAX_B:2]} inside the top module, because the
//             pc width depends on a module parameter.
//  Revision : 1.0 - initial release
// ============================================================================
package jzjpcc_fetch_pkg;

  localparam logic [29:0] NOP_INSTR_30 = 30'(32'h13 >> 2);

  // PC occupies bits [pc_max_b:2]
  function automatic int pc_width(input int pc_max_b);
    return pc_max_b - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jzjpcc_fetch_buffered_if.sv
`default_nettype none
// ============================================================================
//  Module   : jzjpcc_fetch_buffered_if
//  Purpose  : Bus bundle between the fetch stage, the instruction SRAM and
//             the decode stage.
//  Signals  : instruction_fetch          SRAM read data (1 cycle after enable)
//             instructionAddressToLatch  word address presented to the SRAM
//             instructionFetchEnable     SRAM latches the address when 1
//             pcCTWriteEnable            redirect request from decode
//             controlTransferNewPC       redirect target
//             stall_decode / flush_decode decode register control
//             instruction_decode / currentPC_decode / bubble_decode
//                                        decode register outputs
//  Modports : master - the fetch stage; slave - its environment
//  Revision : 1.0 - initial release
// ============================================================================
interface jzjpcc_fetch_buffered_if #(
  parameter int PC_MAX_B = 15
);
  logic [31:2]       instruction_fetch;
  logic [PC_MAX_B:2] instructionAddressToLatch;
  logic              instructionFetchEnable;
  logic              pcCTWriteEnable;
  logic [PC_MAX_B:2] controlTransferNewPC;
  logic              stall_decode;
  logic              flush_decode;
  logic [31:2]       instruction_decode;
  logic [PC_MAX_B:2] currentPC_decode;
  logic              bubble_decode;

  modport master (
    input  instruction_fetch, pcCTWriteEnable, controlTransferNewPC,
           stall_decode, flush_decode,
    output instructionAddressToLatch, instructionFetchEnable,
           instruction_decode, currentPC_decode, bubble_decode
  );

  modport slave (
    output instruction_fetch, pcCTWriteEnable, controlTransferNewPC,
           stall_decode, flush_decode,
    input  instructionAddressToLatch, instructionFetchEnable,
           instruction_decode, currentPC_decode, bubble_decode
  );
endinterface
`default_nettype wire

// File: rtl/jzjpcc_fetch_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : jzjpcc_fetch_fifo
//  Purpose  : Synchronous prefetch FIFO, first-word-fall-through head.
//  Ports    : clock, reset  - clock / synchronous active-high reset
//             push, din     - write din at the tail
//             pop           - drop the head entry
//             clear         - empty the FIFO (overrides push and pop)
//             head          - current head entry (valid when count != 0)
//             count         - occupancy, 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module jzjpcc_fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rdPtr_q;
  logic [AW-1:0]    wrPtr_q;
  logic [CW-1:0]    count_q;

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clock) begin
    if (push && !clear) begin
      mem_q[wrPtr_q] <= din;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wrPtr_q <= wrPtr_q + AW'(1);
      if (pop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign head  = mem_q[rdPtr_q];
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/jzjpcc_fetch_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : jzjpcc_fetch_buffered
//  Purpose  : Fetch stage with a prefetch FIFO between the instruction SRAM
//             and the decode registers. Fetch keeps issuing while decode is
//             stalled, limited by FIFO credit; a control transfer squashes
//             buffered and in-flight instructions and redirects the same cycle.
//  Ports    : clock, reset - clock / synchronous active-high reset
//             bus          - jzjpcc_fetch_buffered_if.master (SRAM + decode)
//  Revision : 1.0 - initial release
// ============================================================================
module jzjpcc_fetch_buffered
  import jzjpcc_fetch_pkg::*;
#(
  parameter int          PC_MAX_B     = 15,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  jzjpcc_fetch_buffered_if.master bus
);
  localparam int PCW = pc_width(PC_MAX_B);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int EW  = 30 + PCW;

  logic [PCW-1:0] fetchPC_q, fetchPC_d;
  logic           inFlight_q, inFlight_d;
  logic [PCW-1:0] inFlightPC_q, inFlightPC_d;
  logic [29:0]    instrDecode_q;
  logic [PCW-1:0] pcDecode_q;
  logic           bubbleDecode_q;

  logic           redirect, respValid, advance, fifoPush, fifoPop, bypass;
  logic           enable;
  logic [PCW-1:0] addr;
  logic [CW-1:0]  used;
  logic [CW-1:0]  fifoCount;
  logic [EW-1:0]  fifoHead;

  always_comb begin
    redirect  = bus.pcCTWriteEnable;
    // A response landing during a redirect belongs to the squashed stream.
    respValid = inFlight_q && !redirect;
    advance   = !redirect && !bus.flush_decode && !bus.stall_decode;
    fifoPop   = advance && (fifoCount != '0);
    bypass    = advance && (fifoCount == '0) && respValid;
    fifoPush  = respValid && !bypass;
    // Credit: every issued request has a guaranteed FIFO slot on return.
    used      = fifoCount + CW'(inFlight_q);
    enable    = !reset && (redirect || (used < CW'(FIFO_DEPTH)));
    addr      = redirect ? bus.controlTransferNewPC : fetchPC_q;
    fetchPC_d    = enable ? addr + PCW'(1) : fetchPC_q;
    inFlight_d   = enable;
    inFlightPC_d = addr;
  end

  jzjpcc_fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifoPush),
    .pop   (fifoPop),
    .clear (redirect),
    .din   ({bus.instruction_fetch, inFlightPC_q}),
    .head  (fifoHead),
    .count (fifoCount)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      fetchPC_q    <= RESET_VECTOR[PC_MAX_B:2];
      inFlight_q   <= 1'b0;
      inFlightPC_q <= '0;
    end else begin
      fetchPC_q    <= fetchPC_d;
      inFlight_q   <= inFlight_d;
      inFlightPC_q <= inFlightPC_d;
    end
  end

  // Decode registers; the PC is left untouched when a nop is injected.
  always_ff @(posedge clock) begin
    if (reset) begin
      instrDecode_q  <= NOP_INSTR_30;
      pcDecode_q     <= '0;
      bubbleDecode_q <= 1'b1;
    end else if (redirect || bus.flush_decode) begin
      instrDecode_q  <= NOP_INSTR_30;
      bubbleDecode_q <= 1'b1;
    end else if (bus.stall_decode) begin
      bubbleDecode_q <= bubbleDecode_q;
    end else if (fifoCount != '0) begin
      {instrDecode_q, pcDecode_q} <= fifoHead;
      bubbleDecode_q              <= 1'b0;
    end else if (respValid) begin
      instrDecode_q  <= bus.instruction_fetch;
      pcDecode_q     <= inFlightPC_q;
      bubbleDecode_q <= 1'b0;
    end else begin
      instrDecode_q  <= NOP_INSTR_30;
      bubbleDecode_q <= 1'b1;
    end
  end

  assign bus.instructionAddressToLatch = addr;
  assign bus.instructionFetchEnable    = enable;
  assign bus.instruction_decode        = instrDecode_q;
  assign bus.currentPC_decode          = pcDecode_q;
  assign bus.bubble_decode             = bubbleDecode_q;

endmodule
`default_nettype wire

// File: tb/tb_jzjpcc_fetch_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : tb_jzjpcc_fetch_buffered
//  Purpose  : Directed self-checking bench. Instance A (PC_MAX_B=15,
//             RESET_VECTOR=0x100) covers reset, streaming, stall, redirect,
//             flush and mid-run reset; instance B (PC_MAX_B=4,
//             RESET_VECTOR=0x18) covers PC wrap. The SRAM models return the
//             word address as the instruction.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_jzjpcc_fetch_buffered;
  import jzjpcc_fetch_pkg::*;

  logic clk = 1'b0;
  logic rstA;
  logic rstB;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  jzjpcc_fetch_buffered_if #(.PC_MAX_B(15)) busA ();
  jzjpcc_fetch_buffered_if #(.PC_MAX_B(4))  busB ();

  jzjpcc_fetch_buffered #(
    .PC_MAX_B(15), .RESET_VECTOR(32'h100), .FIFO_DEPTH(4)
  ) dutA (
    .clock (clk), .reset (rstA), .bus (busA.master)
  );

  jzjpcc_fetch_buffered #(
    .PC_MAX_B(4), .RESET_VECTOR(32'h18), .FIFO_DEPTH(4)
  ) dutB (
    .clock (clk), .reset (rstB), .bus (busB.master)
  );

  // Synchronous SRAMs: data = latched word address, one cycle later.
  always @(posedge clk) begin
    if (busA.instructionFetchEnable) busA.instruction_fetch <= 30'(busA.instructionAddressToLatch);
    if (busB.instructionFetchEnable) busB.instruction_fetch <= 30'(busB.instructionAddressToLatch);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstA = 1'b1;
    tick();
    n_checks++; if (busA.instruction_decode !== NOP_INSTR_30) begin n_fail++; $display("FAIL reset_instr: got %h want %h", busA.instruction_decode, NOP_INSTR_30); end
    n_checks++; if (busA.currentPC_decode !== 14'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", busA.currentPC_decode); end
    n_checks++; if (busA.bubble_decode !== 1'b1) begin n_fail++; $display("FAIL reset_bubble: got %b want 1", busA.bubble_decode); end
    n_checks++; if (busA.instructionFetchEnable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %b want 0", busA.instructionFetchEnable); end
    rstA = 1'b0;
    #1;
    n_checks++; if (busA.instructionAddressToLatch !== 14'h40) begin n_fail++; $display("FAIL first_addr: got %h want 40", busA.instructionAddressToLatch); end
    n_checks++; if (busA.instructionFetchEnable !== 1'b1) begin n_fail++; $display("FAIL first_enable: got %b want 1", busA.instructionFetchEnable); end
    tick();
    n_checks++; if (busA.bubble_decode !== 1'b1 || busA.instruction_decode !== NOP_INSTR_30) begin n_fail++; $display("FAIL second_edge_bubble: got bubble=%b instr=%h want 1/%h", busA.bubble_decode, busA.instruction_decode, NOP_INSTR_30); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (busA.currentPC_decode !== 14'(32'h40 + i) || busA.instruction_decode !== 30'(32'h40 + i) || busA.bubble_decode !== 1'b0) begin n_fail++; $display("FAIL stream_%0d: got pc=%h instr=%h bubble=%b want pc=%h", i, busA.currentPC_decode, busA.instruction_decode, busA.bubble_decode, 32'h40 + i); end
    end
  endtask

  task automatic test_stall();
    busA.stall_decode = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (busA.currentPC_decode !== 14'h42 || busA.bubble_decode !== 1'b0) begin n_fail++; $display("FAIL stall_hold_%0d: got pc=%h bubble=%b want 42/0", i, busA.currentPC_decode, busA.bubble_decode); end
      n_checks++; if (busA.instructionFetchEnable !== (i < 2)) begin n_fail++; $display("FAIL stall_credit_%0d: got enable=%b want %b", i, busA.instructionFetchEnable, (i < 2)); end
    end
    busA.stall_decode = 1'b0;
    #1;
    n_checks++; if (busA.instructionFetchEnable !== 1'b0) begin n_fail++; $display("FAIL release_enable: got %b want 0", busA.instructionFetchEnable); end
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++; if (busA.currentPC_decode !== 14'(32'h43 + i) || busA.instruction_decode !== 30'(32'h43 + i) || busA.bubble_decode !== 1'b0) begin n_fail++; $display("FAIL drain_%0d: got pc=%h bubble=%b want pc=%h", i, busA.currentPC_decode, busA.bubble_decode, 32'h43 + i); end
    end
  endtask

  task automatic test_redirect();
    busA.stall_decode = 1'b1;
    tick();
    busA.stall_decode         = 1'b0;
    busA.pcCTWriteEnable      = 1'b1;
    busA.controlTransferNewPC = 14'h200;
    #1;
    n_checks++; if (busA.instructionAddressToLatch !== 14'h200 || busA.instructionFetchEnable !== 1'b1) begin n_fail++; $display("FAIL redirect_addr: got addr=%h en=%b want 200/1", busA.instructionAddressToLatch, busA.instructionFetchEnable); end
    tick();
    busA.pcCTWriteEnable = 1'b0;
    n_checks++; if (busA.bubble_decode !== 1'b1 || busA.instruction_decode !== NOP_INSTR_30) begin n_fail++; $display("FAIL redirect_nop: got bubble=%b instr=%h want 1/%h", busA.bubble_decode, busA.instruction_decode, NOP_INSTR_30); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (busA.currentPC_decode !== 14'(32'h200 + i) || busA.bubble_decode !== 1'b0) begin n_fail++; $display("FAIL redirect_seq_%0d: got pc=%h bubble=%b want pc=%h", i, busA.currentPC_decode, busA.bubble_decode, 32'h200 + i); end
    end
  endtask

  task automatic test_redirect_stall();
    busA.stall_decode = 1'b1;
    tick();
    n_checks++; if (busA.currentPC_decode !== 14'h202) begin n_fail++; $display("FAIL rs_hold: got pc=%h want 202", busA.currentPC_decode); end
    busA.pcCTWriteEnable      = 1'b1;
    busA.controlTransferNewPC = 14'h300;
    tick();
    busA.pcCTWriteEnable = 1'b0;
    busA.stall_decode    = 1'b0;
    n_checks++; if (busA.bubble_decode !== 1'b1 || busA.instruction_decode !== NOP_INSTR_30) begin n_fail++; $display("FAIL rs_nop: got bubble=%b instr=%h want 1/%h", busA.bubble_decode, busA.instruction_decode, NOP_INSTR_30); end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++; if (busA.currentPC_decode !== 14'(32'h300 + i) || busA.bubble_decode !== 1'b0) begin n_fail++; $display("FAIL rs_seq_%0d: got pc=%h bubble=%b want pc=%h", i, busA.currentPC_decode, busA.bubble_decode, 32'h300 + i); end
    end
  endtask

  task automatic test_flush();
    busA.stall_decode = 1'b1;
    tick();
    tick();
    n_checks++; if (busA.currentPC_decode !== 14'h301) begin n_fail++; $display("FAIL flush_pre: got pc=%h want 301", busA.currentPC_decode); end
    busA.stall_decode = 1'b0;
    busA.flush_decode = 1'b1;
    tick();
    busA.flush_decode = 1'b0;
    n_checks++; if (busA.bubble_decode !== 1'b1 || busA.instruction_decode !== NOP_INSTR_30) begin n_fail++; $display("FAIL flush_nop: got bubble=%b instr=%h want 1/%h", busA.bubble_decode, busA.instruction_decode, NOP_INSTR_30); end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++; if (busA.currentPC_decode !== 14'(32'h302 + i) || busA.instruction_decode !== 30'(32'h302 + i) || busA.bubble_decode !== 1'b0) begin n_fail++; $display("FAIL flush_seq_%0d: got pc=%h bubble=%b want pc=%h", i, busA.currentPC_decode, busA.bubble_decode, 32'h302 + i); end
    end
  endtask

  task automatic test_reset_mid();
    rstA = 1'b1;
    #1;
    n_checks++; if (busA.instructionFetchEnable !== 1'b0) begin n_fail++; $display("FAIL mid_reset_enable: got %b want 0", busA.instructionFetchEnable); end
    tick();
    n_checks++; if (busA.instruction_decode !== NOP_INSTR_30 || busA.currentPC_decode !== 14'h0 || busA.bubble_decode !== 1'b1) begin n_fail++; $display("FAIL mid_reset_state: got instr=%h pc=%h bubble=%b want %h/0/1", busA.instruction_decode, busA.currentPC_decode, busA.bubble_decode, NOP_INSTR_30); end
    rstA = 1'b0;
    #1;
    n_checks++; if (busA.instructionAddressToLatch !== 14'h40 || busA.instructionFetchEnable !== 1'b1) begin n_fail++; $display("FAIL mid_reset_addr: got addr=%h en=%b want 40/1", busA.instructionAddressToLatch, busA.instructionFetchEnable); end
    tick();
    n_checks++; if (busA.bubble_decode !== 1'b1) begin n_fail++; $display("FAIL mid_reset_bubble: got %b want 1", busA.bubble_decode); end
    tick();
    n_checks++; if (busA.currentPC_decode !== 14'h40 || busA.bubble_decode !== 1'b0) begin n_fail++; $display("FAIL mid_reset_first: got pc=%h bubble=%b want 40/0", busA.currentPC_decode, busA.bubble_decode); end
  endtask

  task automatic test_wrap();
    logic [2:0] expAddr [4];
    expAddr[0] = 3'd6; expAddr[1] = 3'd7; expAddr[2] = 3'd0; expAddr[3] = 3'd1;
    rstB = 1'b0;
    #1;
    n_checks++; if (busB.instructionAddressToLatch !== 3'd6 || busB.instructionFetchEnable !== 1'b1) begin n_fail++; $display("FAIL wrap_addr_0: got %h en=%b want 6/1", busB.instructionAddressToLatch, busB.instructionFetchEnable); end
    for (int i = 1; i < 6; i++) begin
      tick();
      if (i < 4) begin
        n_checks++; if (busB.instructionAddressToLatch !== expAddr[i]) begin n_fail++; $display("FAIL wrap_addr_%0d: got %h want %h", i, busB.instructionAddressToLatch, expAddr[i]); end
      end
      if (i >= 2) begin
        n_checks++; if (busB.currentPC_decode !== expAddr[i-2] || busB.instruction_decode !== 30'(expAddr[i-2]) || busB.bubble_decode !== 1'b0) begin n_fail++; $display("FAIL wrap_pc_%0d: got pc=%h bubble=%b want %h", i, busB.currentPC_decode, busB.bubble_decode, expAddr[i-2]); end
      end
    end
  endtask

  initial begin
    rstA = 1'b1;
    rstB = 1'b1;
    busA.pcCTWriteEnable = 1'b0; busA.controlTransferNewPC = '0;
    busA.stall_decode    = 1'b0; busA.flush_decode         = 1'b0;
    busB.pcCTWriteEnable = 1'b0; busB.controlTransferNewPC = '0;
    busB.stall_decode    = 1'b0; busB.flush_decode         = 1'b0;
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_flush();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
